// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO
// Stalls the pipeline while an operation is in flight; a flush aborts it without committing.
module muldiv_unit #(
    parameter int MUL_LAT   = 3,
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    localparam logic [4:0] MUL_LAST = 5'(MUL_LAT - 1);
    localparam logic [4:0] DIV_LAST = 5'(DIV_ITERS - 1);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_signed;
    logic [31:0] r_dvs;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div0;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_acc_signed;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic [32:0] w_rem_sh;
    logic [32:0] w_sub;
    logic        w_ge;
    logic [31:0] w_rem_nx;
    logic [31:0] w_quo_nx;

    assign w_accept     = (r_state == S_IDLE) && valid_i && (op_i <= 3'd3) && !flush_i;
    assign w_acc_signed = ~op_i[0];
    assign w_a_abs      = (w_acc_signed && a_i[31]) ? (~a_i + 32'd1) : a_i;
    assign w_b_abs      = (w_acc_signed && b_i[31]) ? (~b_i + 32'd1) : b_i;

    // The low 64 bits of a 64x64 product of extended operands are exact for both signednesses.
    assign w_a_ext = r_signed ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
    assign w_b_ext = r_signed ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // r_quo shifts the dividend out of its MSB while quotient bits enter at the LSB.
    assign w_rem_sh = {r_rem, r_quo[31]};
    assign w_sub    = w_rem_sh - {1'b0, r_dvs};
    assign w_ge     = ~w_sub[32];
    assign w_rem_nx = w_ge ? w_sub[31:0] : w_rem_sh[31:0];
    assign w_quo_nx = {r_quo[30:0], w_ge};

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy_o = 1'b0;
        done_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_o = w_accept;
                if (w_accept) w_next = op_i[1] ? S_DIV : S_MUL;
            end
            S_MUL: begin
                busy_o = 1'b1;
                if (flush_i)                w_next = S_IDLE;
                else if (r_cnt == MUL_LAST) w_next = S_DONE;
            end
            S_DIV: begin
                busy_o = 1'b1;
                if (flush_i)                w_next = S_IDLE;
                else if (r_cnt == DIV_LAST) w_next = S_DONE;
            end
            S_DONE: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a      <= a_i;
                        r_b      <= b_i;
                        r_signed <= w_acc_signed;
                        r_dvs    <= w_b_abs;
                        r_rem    <= '0;
                        r_quo    <= w_a_abs;
                        r_neg_q  <= w_acc_signed & (a_i[31] ^ b_i[31]);
                        r_neg_r  <= w_acc_signed & a_i[31];
                        r_div0   <= (b_i == 32'd0);
                        r_cnt    <= '0;
                    end else if (valid_i && !flush_i && op_i == 3'd4) begin
                        r_hi <= a_i;
                    end else if (valid_i && !flush_i && op_i == 3'd5) begin
                        r_lo <= a_i;
                    end
                end
                S_MUL: begin
                    if (flush_i) begin
                        r_cnt <= '0;
                    end else if (r_cnt == MUL_LAST) begin
                        r_hi  <= w_prod[63:32];
                        r_lo  <= w_prod[31:0];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_DIV: begin
                    if (flush_i) begin
                        r_cnt <= '0;
                    end else begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        if (r_cnt == DIV_LAST) begin
                            r_cnt <= '0;
                            // Divide-by-zero reports the raw dividend rather than a sign-fixed magnitude.
                            if (r_div0) begin
                                r_hi <= r_a;
                                r_lo <= 32'hFFFF_FFFF;
                            end else begin
                                r_hi <= r_neg_r ? (~w_rem_nx + 32'd1) : w_rem_nx;
                                r_lo <= r_neg_q ? (~w_quo_nx + 32'd1) : w_quo_nx;
                            end
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed table-driven bench for muldiv_unit
// Hand-computed HI/LO results, latencies and flush/back-to-back sequences.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.MUL_LAT(3)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .busy_o(busy_o),
        .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Issue one op at a negedge, then count cycles to done_o; inputs are idle afterwards.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int lat);
        int n;
        int nbusy;
        @(negedge clk);
        valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
        #1 chk({name, " accept busy"}, 32'(busy_o), 32'd1);
        @(posedge clk);
        #1 valid_i = 1'b0; op_i = 3'd7;
        n = 0; nbusy = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (done_o) break;
            if (busy_o) nbusy++;
        end
        chk({name, " latency"}, 32'(n), 32'(lat));
        chk({name, " busy cycles"}, 32'(nbusy), 32'(lat - 1));
        chk({name, " done busy"}, 32'(busy_o), 32'd0);
        chk({name, " hi"}, hi_o, ehi);
        chk({name, " lo"}, lo_o, elo);
        @(negedge clk);
        chk({name, " done pulse"}, 32'(done_o), 32'd0);
    endtask

    initial begin
        logic [31:0] save_hi;
        logic [31:0] save_lo;
        int n;
        vecs[0] = '{"MULT -2*3",   3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 4};
        vecs[1] = '{"MULTU fe*3",  3'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 4};
        vecs[2] = '{"DIV -7/2",    3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[3] = '{"DIVU 7/2",    3'd3, 32'd7,        32'd2,        32'd1,        32'd3,        33};
        vecs[4] = '{"DIVU 5/0",    3'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 33};
        vecs[5] = '{"DIV min/-1",  3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33};
        vecs[6] = '{"DIV -7/0",    3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 33};
        vecs[7] = '{"DIV 7/-2",    3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
        vecs[8] = '{"MULT min^2",  3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 4};
        vecs[9] = '{"MULTU ff^2",  3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 4};

        reset = 1'b1; valid_i = 1'b0; op_i = 3'd7; a_i = '0; b_i = '0; flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset hi", hi_o, 32'd0);
        chk("reset lo", lo_o, 32'd0);
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset done", 32'(done_o), 32'd0);

        valid_i = 1'b1; op_i = 3'd4; a_i = 32'h12345678;
        #1 chk("mthi busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        chk("mthi done", 32'(done_o), 32'd0);
        chk("mthi hi", hi_o, 32'h12345678);
        op_i = 3'd5; a_i = 32'h9ABCDEF0;
        #1 chk("mtlo busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        valid_i = 1'b0;
        chk("mtlo done", 32'(done_o), 32'd0);
        chk("mtlo hi", hi_o, 32'h12345678);
        chk("mtlo lo", lo_o, 32'h9ABCDEF0);

        valid_i = 1'b1; op_i = 3'd6; a_i = 32'hDEADBEEF;
        @(negedge clk);
        valid_i = 1'b0;
        chk("noop hi", hi_o, 32'h12345678);
        chk("noop lo", lo_o, 32'h9ABCDEF0);

        valid_i = 1'b1; op_i = 3'd4; flush_i = 1'b1;
        #1 chk("flush idle busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        valid_i = 1'b0; flush_i = 1'b0;
        chk("flush blocks mthi", hi_o, 32'h12345678);

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].lat);

        // Flush a DIV at T+10: HI/LO keep the previous result and no done_o appears.
        save_hi = hi_o; save_lo = lo_o;
        @(negedge clk);
        valid_i = 1'b1; op_i = 3'd3; a_i = 32'd1000; b_i = 32'd3;
        @(posedge clk);
        #1 valid_i = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush busy", 32'(busy_o), 32'd0);
        chk("flush done", 32'(done_o), 32'd0);
        chk("flush hi", hi_o, save_hi);
        chk("flush lo", lo_o, save_lo);
        run_op("MULT after flush", 3'd0, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6, 4);

        // Back-to-back: MULT held valid through DONE, DIVU accepted in the following IDLE cycle.
        @(negedge clk);
        valid_i = 1'b1; op_i = 3'd0; a_i = 32'd3; b_i = 32'd4;
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (done_o) break;
        end
        chk("b2b mult latency", 32'(n), 32'd4);
        chk("b2b mult hi", hi_o, 32'd0);
        chk("b2b mult lo", lo_o, 32'd12);
        chk("b2b done busy", 32'(busy_o), 32'd0);
        valid_i = 1'b0;
        run_op("b2b DIVU 100/7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
